fp16_sub_pipeline: RTL and testbench

//  Pipelined IEEE-754 half-precision subtractor, result = a - b. Companion to the FP16 adder pipeline.

---
 rtl/fp16_sub_pipeline.sv | 130 +++++++++++++
 tb/tb_fp16_sub_pipeline.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_sub_pipeline.sv
// fp16_sub_pipeline: 4-stage FP16 a - b (a + b via op_add when FP16_SUB_ADD_MODE_EN), truncating, flush-to-zero.
// Latency 4, throughput 1/cycle; every stage holds while out_valid && !out_ready, which also drops in_ready.
module fp16_sub_pipeline #(
  parameter int          STAGES   = 4,
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk73,
  input  logic        rst73_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] numA,
  input  logic [15:0] numB,
`ifdef FP16_SUB_ADD_MODE_EN
  input  logic        op_add,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff
);

  logic [STAGES-1:0] vld;
  logic              advance;

  assign advance   = !vld[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld[STAGES-1];

  logic sub_op;
`ifdef FP16_SUB_ADD_MODE_EN
  assign sub_op = !op_add;
`else
  assign sub_op = 1'b1;
`endif

  // Zero exponent flushes the whole operand to zero magnitude.
  logic [14:0] mag_a, mag_b, mag_l, mag_s;
  logic        sign_b, swap;

  assign mag_a  = (numA[14:10] == 5'd0) ? 15'd0 : numA[14:0];
  assign mag_b  = (numB[14:10] == 5'd0) ? 15'd0 : numB[14:0];
  assign sign_b = numB[15] ^ sub_op;
  assign swap   = mag_b > mag_a;
  assign mag_l  = swap ? mag_b : mag_a;
  assign mag_s  = swap ? mag_a : mag_b;

  logic        s1_nan, s1_sign, s1_sub;
  logic [4:0]  s1_exp, s1_shift;
  logic [10:0] s1_man_l, s1_man_s;

  logic        s2_nan, s2_sign, s2_sub;
  logic [4:0]  s2_exp;
  logic [10:0] s2_man_l, s2_man_s;

  logic        s3_nan, s3_sign;
  logic [4:0]  s3_exp;
  logic [11:0] s3_sum;

  logic [3:0]  lead, lshift;
  logic [10:0] norm_man;
  logic [15:0] res;

  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (s3_sum[i]) lead = 4'(i);
    end
    lshift   = 4'd10 - lead;
    norm_man = s3_sum[10:0] << lshift;
    res      = 16'h0000;
    if (s3_nan) begin
      res = NAN_CODE;
    end else if (s3_sum[11]) begin
      if (s3_exp >= 5'd30) res = {s3_sign, 15'h7C00};
      else                 res = {s3_sign, s3_exp + 5'd1, s3_sum[10:1]};
    end else if (s3_sum != 12'd0 && s3_exp > {1'b0, lshift}) begin
      // Underflow and exact cancellation both fall through to +0.
      res = {s3_sign, s3_exp - {1'b0, lshift}, norm_man[9:0]};
    end
  end

  always_ff @(posedge clk73 or negedge rst73_n) begin
    if (!rst73_n) begin
      vld      <= '0;
      s1_nan   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_exp   <= 5'd0;
      s1_shift <= 5'd0;
      s1_man_l <= 11'd0;
      s1_man_s <= 11'd0;
      s2_nan   <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sub   <= 1'b0;
      s2_exp   <= 5'd0;
      s2_man_l <= 11'd0;
      s2_man_s <= 11'd0;
      s3_nan   <= 1'b0;
      s3_sign  <= 1'b0;
      s3_exp   <= 5'd0;
      s3_sum   <= 12'd0;
      diff     <= 16'h0000;
    end else if (advance) begin
      vld      <= {vld[STAGES-2:0], in_valid};

      s1_nan   <= (&numA[14:10]) | (&numB[14:10]);
      s1_sign  <= swap ? sign_b : numA[15];
      s1_sub   <= numA[15] ^ sign_b;
      s1_exp   <= mag_l[14:10];
      s1_shift <= mag_l[14:10] - mag_s[14:10];
      s1_man_l <= {|mag_l[14:10], mag_l[9:0]};
      s1_man_s <= {|mag_s[14:10], mag_s[9:0]};

      s2_nan   <= s1_nan;
      s2_sign  <= s1_sign;
      s2_sub   <= s1_sub;
      s2_exp   <= s1_exp;
      s2_man_l <= s1_man_l;
      s2_man_s <= (s1_shift >= 5'd12) ? 11'd0 : (s1_man_s >> s1_shift);

      s3_nan   <= s2_nan;
      s3_sign  <= s2_sign;
      s3_exp   <= s2_exp;
      s3_sum   <= s2_sub ? ({1'b0, s2_man_l} - {1'b0, s2_man_s})
                         : ({1'b0, s2_man_l} + {1'b0, s2_man_s});

      diff     <= res;
    end
  end

endmodule

// File: tb/tb_fp16_sub_pipeline.sv
// Bench for fp16_sub_pipeline: directed vectors, stall/backpressure burst, random traffic vs an integer model, async reset.
module tb_fp16_sub_pipeline;

  logic        clk73 = 1'b0;
  logic        rst73_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] numA = 16'h0, numB = 16'h0, diff;
  logic        op_add = 1'b0;

  int          tests = 0, fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp = 16'h0;
  bit          held = 1'b0;
  logic [15:0] held_diff = 16'h0;

  logic [15:0] dir_a[10] = '{16'h5630, 16'h5620, 16'h563E, 16'h0000, 16'h0000,
                             16'h7BFF, 16'h7C00, 16'h0401, 16'h3C00, 16'h5948};
  logic [15:0] dir_b[10] = '{16'h5590, 16'hD948, 16'h563E, 16'h5750, 16'h0000,
                             16'hFBFF, 16'h3C00, 16'h0400, 16'hFE00, 16'h5620};
  logic [15:0] dir_e[10] = '{16'h4900, 16'h5C2C, 16'h0000, 16'hD750, 16'h0000,
                             16'h7C00, 16'h7E00, 16'h0000, 16'h7E00, 16'h5470};

  always #5 clk73 = ~clk73;

  fp16_sub_pipeline dut (
    .clk73     (clk73),
    .rst73_n   (rst73_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .numA      (numA),
    .numB      (numB),
`ifdef FP16_SUB_ADD_MODE_EN
    .op_add    (op_add),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
  );

  // Reference: integer mantissas, align with truncation, add/sub, renormalize.
  function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic add);
    int   ea, eb, ma, mb, el, es, ml, ms, r, e;
    logic sa, sb, sl, ss;
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return 16'h7E00;
    sa = a[15];
    sb = b[15] ^ !add;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    if (eb > ea || (eb == ea && mb > ma)) begin
      el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
    end else begin
      el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
    end
    r = (el - es >= 12) ? 0 : (ms >> (el - es));
    r = (sl == ss) ? ml + r : ml - r;
    if (r == 0) return 16'h0000;
    e = el;
    while (r >= 2048) begin r = r >> 1; e++; end
    while (r < 1024) begin r = r << 1; e--; end
    if (e >= 31) return {sl, 15'h7C00};
    if (e < 1) return 16'h0000;
    return {sl, e[4:0], r[9:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: sample before the edge, score transfers after it, return at the next negedge.
  task automatic tick(output bit acc);
    bit          ai, ao;
    logic [15:0] od;
    #1;
    ai = in_valid && in_ready;
    ao = out_valid && out_ready;
    od = diff;
    if (held) begin
      check("stall_valid", {15'b0, out_valid}, 16'd1);
      check("stall_diff", diff, held_diff);
    end
    held = out_valid && !out_ready;
    if (held) begin
      held_diff = diff;
      check("stall_in_ready", {15'b0, in_ready}, 16'd0);
    end
    @(posedge clk73);
    if (ao) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_out: observed output %h expected none", od);
      end
      if (exp_q.size() != 0) check("result", od, exp_q.pop_front());
    end
    if (ai) exp_q.push_back(cur_exp);
    acc = ai;
    @(negedge clk73);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    bit acc;
    acc = 1'b0;
    numA = a; numB = b; cur_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) tick(acc);
    in_valid = 1'b0;
    tests++;
    assert (acc) else begin
      fails++;
      $error("FAIL accept: operands %h/%h observed not accepted expected accepted", a, b);
    end
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick(acc);
    check("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic gen(output logic [15:0] a, output logic [15:0] b);
    a = 16'($urandom);
    case ($urandom_range(0, 5))
      0, 1: b = 16'($urandom);
      2:    b = {1'($urandom), a[14:10], 10'($urandom)};
      3:    b = {1'($urandom), (a[14:10] == 5'd0) ? 5'd0 : a[14:10] - 5'd1, 10'($urandom)};
      4:    b = {1'($urandom), a[14:0]};
      default: begin
        b = 16'($urandom);
        if ($urandom_range(0, 1) == 1) a = {1'($urandom), 15'h0};
        else                           b = {1'($urandom), 15'h0};
      end
    endcase
  endtask

  initial begin
    bit          acc, have;
    int          sent;
    logic [15:0] a, b;
    logic [15:0] ba[8], bb[8];

    #3;
    check("rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst_diff", diff, 16'h0000);
    #9 rst73_n = 1'b1;
    @(negedge clk73);
    check("in_ready_after_rst", {15'b0, in_ready}, 16'd1);

    // Latency: result visible exactly four edges after the transfer edge.
    numA = 16'h5948; numB = 16'h5620; cur_exp = 16'h5470; in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check("lat_no_early", {15'b0, out_valid}, 16'd0);
      tick(acc);
    end
    check("lat_valid", {15'b0, out_valid}, 16'd1);
    check("lat_diff", diff, 16'h5470);
    drain();

    for (int i = 0; i < 10; i++) send(dir_a[i], dir_b[i], dir_e[i]);
    drain();

    // Back-to-back burst with the consumer stalled in cycles 6-8.
    for (int i = 0; i < 8; i++) gen(ba[i], bb[i]);
    sent = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        numA = ba[sent]; numB = bb[sent]; cur_exp = ref_sub(ba[sent], bb[sent], op_add); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) sent++;
    end
    check("burst_sent", 16'(sent), 16'd8);
    drain();

    // Random traffic with bubbles and random backpressure.
    sent = 0;
    have = 1'b0;
    for (int cyc = 0; cyc < 3000 && sent < 200; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!have && $urandom_range(0, 9) < 8) begin
        gen(a, b);
`ifdef FP16_SUB_ADD_MODE_EN
        op_add = 1'($urandom);
`endif
        numA = a; numB = b; cur_exp = ref_sub(a, b, op_add); have = 1'b1;
      end
      in_valid = have;
      tick(acc);
      if (acc) begin have = 1'b0; sent++; end
    end
    in_valid = 1'b0;
    check("random_sent", 16'(sent), 16'd200);
    drain();

    // Asynchronous reset with results in flight.
    op_add = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gen(a, b);
      send(a, b, ref_sub(a, b, op_add));
    end
    check("pre_rst_valid", {15'b0, out_valid}, 16'd1);
    #2 rst73_n = 1'b0;
    #1;
    check("async_rst_valid", {15'b0, out_valid}, 16'd0);
    check("async_rst_diff", diff, 16'h0000);
    exp_q.delete();
    held = 1'b0;
    @(posedge clk73);
    #3;
    check("in_rst_valid", {15'b0, out_valid}, 16'd0);
    #1 rst73_n = 1'b1;
    @(negedge clk73);
    check("post_rst_in_ready", {15'b0, in_ready}, 16'd1);
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      check("no_stale", {15'b0, out_valid}, 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
